// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct
// values, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    // ALU operation class requested by the FSM; aludec resolves it to a code.
    typedef enum logic [2:0] {
        ALUOP_NONE  = 3'd0,
        ALUOP_ADD   = 3'd1,
        ALUOP_SUB   = 3'd2,
        ALUOP_FUNCT = 3'd3,
        ALUOP_IMM   = 3'd4
    } aluop_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU decoder: turns the FSM's operation class plus op/funct into the ALU
// control code and immediate-extension mode, and flags unsupported R-type functs.
module aludec
    import mips_ctrl_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [5:0] funct,
    input  logic [5:0] op,
    output logic [2:0] alucontrol,
    output logic       imm_ext,
    output logic       funct_illegal
);

    logic [2:0] funct_ctrl;

    always_comb begin
        funct_ctrl    = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            F_ADD:   funct_ctrl = ALU_ADD;
            F_SUB:   funct_ctrl = ALU_SUB;
            F_AND:   funct_ctrl = ALU_AND;
            F_OR:    funct_ctrl = ALU_OR;
            F_SLT:   funct_ctrl = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        imm_ext    = 1'b0;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_ctrl;
            ALUOP_IMM: begin
                case (op)
                    OP_ANDI: begin alucontrol = ALU_AND; imm_ext = 1'b1; end
                    OP_ORI:  begin alucontrol = ALU_OR;  imm_ext = 1'b1; end
                    OP_SLTI: alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core: Moore decode of datapath
// controls per state, with memready stalls on FETCH, MEMRD and MEMWR.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       immExt,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   is_sw_q, is_sw_d;

    aluop_e aluop;
    logic   mem_rdy;
    logic   funct_illegal;
    logic   irwrite_raw, regwrite_raw, memwrite_raw, pcwrite_raw, branch_take, illegal_raw;

    assign mem_rdy = MEM_WAIT_EN ? memready : 1'b1;

    aludec u_aludec (
        .aluop         (aluop),
        .funct         (funct),
        .op            (op),
        .alucontrol    (alucontrol),
        .imm_ext       (immExt),
        .funct_illegal (funct_illegal)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    // lw/sw is captured in DECODE so MEMADR never needs to look at op.
    assign is_sw_d = (state_q == S_DECODE) ? (op == OP_SW) : is_sw_q;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        iord         = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = SRCB_REG;
        pcsrc        = PC_ALURES;
        aluop        = ALUOP_NONE;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        pcwrite_raw  = 1'b0;
        branch_take  = 1'b0;
        illegal_raw  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb     = SRCB_FOUR;
                aluop       = ALUOP_ADD;
                irwrite_raw = mem_rdy;
                pcwrite_raw = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                aluop   = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                    OP_J:                              state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_illegal) begin
                            illegal_raw = 1'b1;
                            state_d     = S_FETCH;
                        end else begin
                            state_d = S_RTYPEEX;
                        end
                    end
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
                state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_REG;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                alusrcb     = SRCB_REG;
                aluop       = ALUOP_SUB;
                pcsrc       = PC_ALUOUT;
                branch_take = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
                state_d     = S_FETCH;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_IMM;
                state_d = S_IWB;
            end
            S_IWB: begin
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pcsrc       = PC_JUMP;
                pcwrite_raw = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are gated by reset directly so they drop asynchronously with it.
    assign irwrite  = irwrite_raw  & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign pcen     = (pcwrite_raw | branch_take) & ~reset;
    assign illegal  = illegal_raw  & ~reset;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through
// the FSM and checks state and control outputs against hand-computed values.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       memtoreg, regdst, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       immExt, irwrite, regwrite, memwrite, pcen, illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memready   (memready),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .iord       (iord),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .immExt     (immExt),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .pcen       (pcen),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        op       = 6'h2B;
        funct    = 6'h00;
        zero     = 1'b0;
        memready = 1'b1;
        #2;
        check("rst_state", 8'(state), 8'd0);
        check("rst_irwrite", 8'(irwrite), 8'd0);
        check("rst_pcen", 8'(pcen), 8'd0);
        #10;
        reset = 1'b0;
        #1;
        check("fetch_irwrite", 8'(irwrite), 8'd1);
        check("fetch_pcen", 8'(pcen), 8'd1);
        check("fetch_alusrcb", 8'(alusrcb), 8'd1);

        // sw to MEMWR, then reset mid-instruction
        tick(); check("sw_decode", 8'(state), 8'd1);
        check("decode_alusrcb", 8'(alusrcb), 8'd3);
        tick(); check("sw_memadr", 8'(state), 8'd2);
        tick(); check("sw_memwr", 8'(state), 8'd5);
        check("sw_memwrite", 8'(memwrite), 8'd1);
        memready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state", 8'(state), 8'd0);
        check("async_rst_memwrite", 8'(memwrite), 8'd0);
        memready = 1'b1;
        #1;
        check("rst_held_irwrite", 8'(irwrite), 8'd0);
        tick(); check("rst_held_state", 8'(state), 8'd0);
        op    = 6'h23;
        reset = 1'b0;
        #1;
        check("post_rst_state", 8'(state), 8'd0);
        check("post_rst_irwrite", 8'(irwrite), 8'd1);
        check("post_rst_pcen", 8'(pcen), 8'd1);

        // lw: 0,1,2,3,4,0
        tick(); check("lw_s1", 8'(state), 8'd1);
        check("lw_s1_regwrite", 8'(regwrite), 8'd0);
        tick(); check("lw_s2", 8'(state), 8'd2);
        check("lw_alusrcb", 8'(alusrcb), 8'd2);
        check("lw_memadr_immext", 8'(immExt), 8'd0);
        tick(); check("lw_s3", 8'(state), 8'd3);
        check("lw_iord", 8'(iord), 8'd1);
        check("lw_s3_regwrite", 8'(regwrite), 8'd0);
        tick(); check("lw_s4", 8'(state), 8'd4);
        check("lw_wb", {5'd0, regwrite, memtoreg, regdst}, 8'b110);
        tick(); check("lw_done", 8'(state), 8'd0);
        check("lw_done_regwrite", 8'(regwrite), 8'd0);

        // sw with two memready-low cycles in MEMWR
        op = 6'h2B;
        tick(); tick(); tick();
        check("sw2_memwr", 8'(state), 8'd5);
        check("sw2_we1", {6'd0, memwrite, regwrite}, 8'b10);
        memready = 1'b0;
        tick(); check("sw2_we2", {4'd0, state}, 8'd5);
        check("sw2_we2_mw", {6'd0, memwrite, regwrite}, 8'b10);
        tick(); check("sw2_we3", {6'd0, memwrite, regwrite}, 8'b10);
        memready = 1'b1;
        tick(); check("sw2_done", 8'(state), 8'd0);
        check("sw2_done_mw", 8'(memwrite), 8'd0);

        // FETCH stall
        memready = 1'b0;
        #1;
        check("fetch_stall_irwrite", 8'(irwrite), 8'd0);
        op = 6'h04;
        tick(); check("fetch_stall_state", 8'(state), 8'd0);
        memready = 1'b1;

        // beq taken / not taken, bne taken / not taken
        tick(); tick();
        check("beq_state", 8'(state), 8'd8);
        zero = 1'b1;
        #1;
        check("beq_taken_pcen", 8'(pcen), 8'd1);
        check("beq_pcsrc", 8'(pcsrc), 8'd1);
        check("beq_alucontrol", 8'(alucontrol), 8'b110);
        zero = 1'b0;
        #1;
        check("beq_nt_pcen", 8'(pcen), 8'd0);
        op = 6'h05;
        tick(); check("beq_done", 8'(state), 8'd0);
        tick(); tick();
        check("bne_state", 8'(state), 8'd8);
        check("bne_taken_pcen", 8'(pcen), 8'd1);
        zero = 1'b1;
        #1;
        check("bne_nt_pcen", 8'(pcen), 8'd0);
        zero = 1'b0;

        // ori then addi
        op = 6'h0D;
        tick(); tick(); tick();
        check("ori_state", 8'(state), 8'd9);
        check("ori_ctrl", {2'd0, immExt, alucontrol, alusrcb}, {2'd0, 1'b1, 3'b001, 2'b10});
        tick(); check("ori_wb", {3'd0, regwrite, state}, {3'd0, 1'b1, 4'd10});
        op = 6'h08;
        tick(); tick(); tick();
        check("addi_ctrl", {1'd0, state, immExt, alucontrol}, {1'd0, 4'd9, 1'b0, 3'b010});
        tick(); tick();

        // R-type slt
        op    = 6'h00;
        funct = 6'h2A;
        tick(); check("rtype_decode_illegal", 8'(illegal), 8'd0);
        tick(); check("rtype_ex", {1'd0, state, alucontrol}, {1'd0, 4'd6, 3'b111});
        tick(); check("rtype_wb", {2'd0, state, regwrite, regdst}, {2'd0, 4'd7, 1'b1, 1'b1});
        tick(); check("rtype_done", 8'(state), 8'd0);

        // jump
        op = 6'h02;
        tick(); tick();
        check("j_state", 8'(state), 8'd11);
        check("j_ctrl", {5'd0, pcen, pcsrc}, {5'd0, 1'b1, 2'b10});
        tick();

        // illegal opcode
        op = 6'h3F;
        tick(); check("illop_state", 8'(state), 8'd1);
        check("illop_pulse", {4'd0, illegal, regwrite, memwrite, pcen}, 8'b1000);
        tick(); check("illop_back", {3'd0, illegal, state}, 8'd0);

        // illegal funct
        op    = 6'h00;
        funct = 6'h00;
        tick(); check("illfn_pulse", {4'd0, illegal, regwrite, memwrite, pcen}, 8'b1000);
        tick(); check("illfn_back", {3'd0, illegal, state}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS core; sits directly upstream of the datapath and drives all of its mux selects, enables and the ALU operation.
- Consumes op and funct from the instruction register and zero from the ALU.
- Adds a memory wait handshake (memready) so the core can run against memories with variable latency.

Parameters:
MEM_WAIT_EN, 1, when 0 memready is ignored and treated as constantly 1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; FSM to FETCH
op  input  6  instr[31:26]
funct  input  6  instr[5:0]
zero  input  1  ALU zero flag
memready  input  1  memory access completes this cycle
memtoreg  output  1  register write data from the memory data register
regdst  output  1  write register = rd (1) or rt (0)
iord  output  1  memory address from aluout (1) or pc (0)
alusrca  output  1  ALU A = register (1) or pc (0)
alusrcb  output  2  00 reg B, 01 constant 4, 10 imm, 11 imm<<2
pcsrc  output  2  00 aluresult, 01 aluout, 10 jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
immExt  output  1  zero-extend immediate (1) or sign-extend (0)
irwrite  output  1  instruction register enable
regwrite  output  1  register file write enable
memwrite  output  1  memory write enable
pcen  output  1  PC enable = pcwrite | (beq & zero) | (bne & ~zero)
illegal  output  1  one-cycle pulse on an unsupported op/funct
state  output  4  current state, for debug

Behaviour:
- Moore FSM; outputs decode from state only, except pcen (uses zero) and the memready-qualified enables.
- Unlisted outputs are 0; mux selects default to 0.
- While reset is high, irwrite, pcen, regwrite, memwrite and illegal are forced 0, and state = FETCH (0).
- Supported instructions: lw 23, sw 2B, R-type 00 (funct 20 add, 22 sub, 24 and, 25 or, 2A slt), beq 04, bne 05, addi 08, andi 0C, ori 0D, slti 0A, j 02.
- States and outputs:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, add, pcsrc=00; irwrite=pcen=memready. Go to DECODE when memready, else hold.
  - DECODE(1): alusrca=0, alusrcb=11, add (precomputes branch target into aluout). Next state by op: lw/sw->MEMADR; R->RTYPEEX; beq/bne->BRANCH; I-ALU->IEXEC; j->JUMP. Unknown op, or R-type with unknown funct: illegal=1, ->FETCH.
  - MEMADR(2): alusrca=1, alusrcb=10, add, immExt=0. lw->MEMRD, sw->MEMWR.
  - MEMRD(3): iord=1. ->MEMWB when memready, else hold.
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1. ->FETCH.
  - MEMWR(5): iord=1, memwrite=1, held while memready=0. ->FETCH when memready.
  - RTYPEEX(6): alusrca=1, alusrcb=00, alucontrol from funct. ->RTYPEWB.
  - RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1. ->FETCH.
  - BRANCH(8): alusrca=1, alusrcb=00, sub, pcsrc=01; pcen=zero (beq) or ~zero (bne). ->FETCH.
  - IEXEC(9): alusrca=1, alusrcb=10. alucontrol: addi add, andi and, ori or, slti slt. immExt=1 for andi/ori, else 0. ->IWB.
  - IWB(10): regdst=0, memtoreg=0, regwrite=1. ->FETCH.
  - JUMP(11): pcsrc=10, pcen=1. ->FETCH.
  - Codes 12-15: unreachable; recover to FETCH next cycle with all enables 0.
- Latency with memready=1: lw 5 cycles; sw, R-type and I-ALU 4; beq, bne and j 3. Each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- op/funct are sampled only in DECODE, RTYPEEX, BRANCH and IEXEC; the instruction register is stable then because irwrite=0.
- Asynchronous reset mid-instruction: abandon immediately; no write enable is asserted after reset deassertion until the next FETCH completes.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state enum (4-bit codes above)
  - opcode and funct constants
  - alucontrol encodings
  - alusrcb and pcsrc select constants
- One sub-module, aludec: combinational (aluop class, funct, op) -> alucontrol, immExt, funct-illegal. The FSM instantiates it.

Test Plan:
- Reset asserted in MEMWR (state=5) -> state=0 immediately and memwrite=0 asynchronously. After release with memready=1: FETCH, irwrite=1, pcen=1.
- lw (op=23), memready=1 -> states 0,1,2,3,4,0. regwrite=1 only in state 4, with memtoreg=1 and regdst=0.
- sw (op=2B), memready low for 2 cycles in MEMWR -> memwrite=1 for 3 consecutive cycles, then state=0; regwrite never 1.
- beq (op=04): zero=1 -> pcen=1 and pcsrc=01 in state 8. zero=0 -> pcen=0. bne (op=05) with zero=0 -> pcen=1.
- ori (op=0D) -> in state 9, immExt=1, alucontrol=001, alusrcb=10; state 10 regwrite=1. addi (op=08) -> immExt=0, alucontrol=010.
- op=3F -> illegal=1 for one cycle in state 1, then state=0; no regwrite, memwrite or pcen outside FETCH. R-type funct=00 -> same response.
